// File: rtl/joypad_input_cond.sv
// joypad_input_cond: button conditioning bank for the joypad matrix.
// Each raw button is synchronised and debounced on a prescaled tick.
// The block also produces press/release pulses, gates all channels from
// the menu, and resolves opposing D-pad directions (SOCD) on btn_out.
// D-pad bit order is {down, up, left, right} on bits [3:0].
module joypad_input_cond #(
  parameter int NUM_BTN   = 8,
  parameter int DEBOUNCE  = 14,
  parameter int CNT_W     = 4,
  parameter int TICK_DIV  = 1,
  parameter int SOCD_MODE = 0
) (
  input  logic               pclk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               btn_enable,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press,
  output logic [NUM_BTN-1:0] btn_out
);

  localparam int                TICK_W    = 16;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);

  // Resolve one opposing pair {member b, member a} according to SOCD_MODE.
  // last: 2'b01 = a pressed most recently, 2'b10 = b, anything else = no
  // single winner (both pressed together), which yields neutral.
  function automatic logic [1:0] socd_pair(input logic [1:0] st, input logic [1:0] last);
    logic [1:0] res;
    case (SOCD_MODE)
      32'd0: begin
        if (st == 2'b11) res = 2'b00;
        else             res = st;
      end
      32'd1: begin
        if (st == 2'b11) begin
          if (last == 2'b01 || last == 2'b10) res = last;
          else                                res = 2'b00;
        end else begin
          res = st;
        end
      end
      default: res = st;
    endcase
    return res;
  endfunction

  // Most-recent-press tracker for one pair; a simultaneous press stores 2'b11.
  function automatic logic [1:0] last_next(input logic [1:0] last, input logic [1:0] pr);
    logic [1:0] res;
    if (pr != 2'b00) res = pr;
    else             res = last;
    return res;
  endfunction

  logic [NUM_BTN-1:0] sync1_r, sync2_r;
  logic [TICK_W-1:0]  tick_cnt_r;
  logic               tick_s;
  logic [CNT_W-1:0]   cnt_r [NUM_BTN];
  logic [CNT_W-1:0]   cnt_s [NUM_BTN];
  logic [NUM_BTN-1:0] state_r, state_s;
  logic [NUM_BTN-1:0] press_r, press_s;
  logic [NUM_BTN-1:0] release_r, release_s;
  logic               any_press_r;
  logic [1:0]         last_lr_r, last_lr_s;
  logic [1:0]         last_ud_r, last_ud_s;
  logic [NUM_BTN-1:0] out_r, out_s;

  assign btn_state   = state_r;
  assign btn_press   = press_r;
  assign btn_release = release_r;
  assign any_press   = any_press_r;
  assign btn_out     = out_r;
  assign tick_s      = (tick_cnt_r == TICK_LAST);

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= {NUM_BTN{1'b0}};
      sync2_r <= {NUM_BTN{1'b0}};
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Sample-tick prescaler: counts 0..TICK_DIV-1 and wraps.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(32'd1);
    end
  end

  // Debounce next state: the gate overrides everything, otherwise counters advance only on tick.
  always_comb begin
    state_s   = state_r;
    press_s   = {NUM_BTN{1'b0}};
    release_s = {NUM_BTN{1'b0}};
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_s[i] = cnt_r[i];
      if (!btn_enable) begin
        // Gate closes: every pressed channel releases at once, nothing presses.
        state_s[i]   = 1'b0;
        cnt_s[i]     = CNT_ZERO;
        release_s[i] = state_r[i];
      end else if (tick_s) begin
        if (sync2_r[i] == state_r[i]) begin
          // Any agreeing sample restarts the window.
          cnt_s[i] = CNT_ZERO;
        end else if (cnt_r[i] == CNT_LAST) begin
          state_s[i]   = sync2_r[i];
          cnt_s[i]     = CNT_ZERO;
          press_s[i]   = sync2_r[i];
          release_s[i] = ~sync2_r[i];
        end else begin
          cnt_s[i] = cnt_r[i] + CNT_ONE;
        end
      end else begin
        cnt_s[i] = cnt_r[i];
      end
    end
  end

  // Debounce registers; pulses are registered alongside the new state.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= {NUM_BTN{1'b0}};
      press_r     <= {NUM_BTN{1'b0}};
      release_r   <= {NUM_BTN{1'b0}};
      any_press_r <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      state_r     <= state_s;
      press_r     <= press_s;
      release_r   <= release_s;
      any_press_r <= |press_s;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_r[i] <= cnt_s[i];
      end
    end
  end

  // SOCD next state: update last-pressed flags from this cycle's pulses, then resolve pairs.
  always_comb begin
    last_lr_s  = last_next(last_lr_r, press_r[1:0]);
    last_ud_s  = last_next(last_ud_r, press_r[3:2]);
    out_s      = state_r;
    out_s[1:0] = socd_pair(state_r[1:0], last_lr_s);
    out_s[3:2] = socd_pair(state_r[3:2], last_ud_s);
  end

  // SOCD registers: btn_out trails btn_state by one cycle.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      last_lr_r <= 2'b00;
      last_ud_r <= 2'b00;
      out_r     <= {NUM_BTN{1'b0}};
    end else begin
      last_lr_r <= last_lr_s;
      last_ud_r <= last_ud_s;
      out_r     <= out_s;
    end
  end

endmodule
